// File: rtl/kws_mac_sequencer.sv
// -----------------------------------------------------------------------------
// kws_mac_sequencer
//
// Command-level controller between the CPU CFU port and the external,
// purely combinational KWS datapath (MAC, rounding doubling high, rounding
// clamping divide-by-power-of-two). It buffers input/filter word pairs in a
// circular FIFO and holds the requantization config. A RUN command sequences
// one output-channel computation: bias load, N MACs, RDH, RCDBPOT. The result
// is returned over the CFU response handshake.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready      CFU command handshake
//   cmd_payload_function_id    [2:0] opcode, [3] simd_en, [4] layer_one_en
//   cmd_payload_inputs_0/1     command operands (rs1, rs2)
//   rsp_valid / rsp_ready      CFU response handshake
//   rsp_payload_outputs_0      response data
//   dp_op                      one-hot datapath select (001 MAC, 010 RDH,
//                              100 RCDBPOT, 000 idle)
//   dp_simd_en, dp_layer_one_en  registered config bits for the MAC
//   dp_in0, dp_in1, dp_acc     datapath operands / current accumulator
//   dp_result                  combinational datapath result for dp_op
// -----------------------------------------------------------------------------
module kws_mac_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic [2:0]  dp_op,
    output logic        dp_simd_en,
    output logic        dp_layer_one_en,
    output logic [31:0] dp_in0,
    output logic [31:0] dp_in1,
    output logic [31:0] dp_acc,
    input  logic [31:0] dp_result
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] OP_PUSH   = 3'd0;
    localparam logic [2:0] OP_CONFIG = 3'd1;
    localparam logic [2:0] OP_RUN    = 3'd2;
    localparam logic [2:0] OP_CLEAR  = 3'd3;

    localparam logic [2:0] DP_IDLE  = 3'b000;
    localparam logic [2:0] DP_MAC   = 3'b001;
    localparam logic [2:0] DP_RDH   = 3'b010;
    localparam logic [2:0] DP_SHIFT = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_RDH,
        S_SHIFT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [31:0]        r_fifo_in  [DEPTH];
    logic [31:0]        r_fifo_flt [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [31:0]        r_acc;
    logic [31:0]        r_mult;
    logic [31:0]        r_shift;
    logic               r_simd_en;
    logic               r_layer_one_en;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_payload;

    logic               w_accept;
    logic [2:0]         w_opcode;
    logic               w_full;
    logic               w_push;
    logic [2:0]         w_dp_op;
    logic [31:0]        w_dp_in0;
    logic [31:0]        w_dp_in1;

    // Function-id bits above the config fields are not decoded.
    logic               w_unused_fid;
    assign w_unused_fid = &{1'b0, cmd_payload_function_id[9:5]};

    assign cmd_ready = (r_state == S_IDLE) && !r_rsp_valid;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_opcode  = cmd_payload_function_id[2:0];
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push    = w_accept && (w_opcode == OP_PUSH) && !w_full;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and datapath drive
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_dp_op      = DP_IDLE;
        w_dp_in0     = '0;
        w_dp_in1     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_opcode == OP_RUN) begin
                        w_next_state = (r_count != '0) ? S_MAC : S_RDH;
                    end else begin
                        w_next_state = S_RESP;
                    end
                end
            end
            S_MAC: begin
                w_dp_op  = DP_MAC;
                w_dp_in0 = r_fifo_in[r_rd_ptr];
                w_dp_in1 = r_fifo_flt[r_rd_ptr];
                // Last entry is being consumed this cycle.
                if (r_count == CNT_W'(1)) begin
                    w_next_state = S_RDH;
                end
            end
            S_RDH: begin
                w_dp_op      = DP_RDH;
                w_dp_in0     = r_acc;
                w_dp_in1     = r_mult;
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                w_dp_op      = DP_SHIFT;
                w_dp_in1     = r_shift;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_in[r_wr_ptr]  <= cmd_payload_inputs_0;
            r_fifo_flt[r_wr_ptr] <= cmd_payload_inputs_1;
        end
    end

    // -------------------------------------------------------------------------
    // Command execution, accumulator and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_acc          <= '0;
            r_mult         <= '0;
            r_shift        <= '0;
            r_simd_en      <= 1'b0;
            r_layer_one_en <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_payload  <= '0;
        end else if (w_accept) begin
            case (w_opcode)
                OP_PUSH: begin
                    r_rsp_valid <= 1'b1;
                    if (!w_full) begin
                        // Pointers wrap naturally because DEPTH is a power of two.
                        r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
                        r_count       <= r_count + CNT_W'(1);
                        r_rsp_payload <= 32'(r_count + CNT_W'(1));
                    end else begin
                        r_rsp_payload <= 32'hFFFF_FFFF;
                    end
                end
                OP_CONFIG: begin
                    r_mult         <= cmd_payload_inputs_0;
                    r_shift        <= cmd_payload_inputs_1;
                    r_simd_en      <= cmd_payload_function_id[3];
                    r_layer_one_en <= cmd_payload_function_id[4];
                    r_rsp_payload  <= '0;
                    r_rsp_valid    <= 1'b1;
                end
                OP_RUN: begin
                    r_acc <= cmd_payload_inputs_0;
                end
                OP_CLEAR: begin
                    r_rd_ptr      <= r_wr_ptr;
                    r_count       <= '0;
                    r_rsp_payload <= 32'(r_count);
                    r_rsp_valid   <= 1'b1;
                end
                default: begin
                    r_rsp_payload <= '0;
                    r_rsp_valid   <= 1'b1;
                end
            endcase
        end else begin
            case (r_state)
                S_MAC: begin
                    r_acc    <= dp_result;
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    r_count  <= r_count - CNT_W'(1);
                end
                S_RDH: begin
                    r_acc <= dp_result;
                end
                S_SHIFT: begin
                    r_rsp_payload <= dp_result;
                    r_rsp_valid   <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid             = r_rsp_valid;
    assign rsp_payload_outputs_0 = r_rsp_payload;
    assign dp_op                 = w_dp_op;
    assign dp_in0                = w_dp_in0;
    assign dp_in1                = w_dp_in1;
    assign dp_acc                = r_acc;
    assign dp_simd_en            = r_simd_en;
    assign dp_layer_one_en       = r_layer_one_en;

endmodule

// File: tb/tb_kws_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_kws_mac_sequencer
//
// Self-checking bench for kws_mac_sequencer (DEPTH=4). Single-cycle commands
// come from a table of {command, expected response} records; RUN sequences,
// response back-pressure and reset-during-RUN are hand-written. A reference
// datapath model drives dp_result from dp_op and the operands.
// -----------------------------------------------------------------------------
module tb_kws_mac_sequencer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic [2:0]  dp_op;
    logic        dp_simd_en;
    logic        dp_layer_one_en;
    logic [31:0] dp_in0;
    logic [31:0] dp_in1;
    logic [31:0] dp_acc;
    logic [31:0] dp_result;

    int n_pass  = 0;
    int n_total = 0;

    kws_mac_sequencer #(.DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .dp_op                   (dp_op),
        .dp_simd_en              (dp_simd_en),
        .dp_layer_one_en         (dp_layer_one_en),
        .dp_in0                  (dp_in0),
        .dp_in1                  (dp_in1),
        .dp_acc                  (dp_acc),
        .dp_result               (dp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference datapath: MAC = acc + in0*in1; RDH = rounding doubling high
    // (Q31 multiply); RCDBPOT = rounding arithmetic shift right by -shift.
    function automatic logic [31:0] dp_model(input logic [2:0] op,
                                             input logic [31:0] in0,
                                             input logic [31:0] in1,
                                             input logic [31:0] acc);
        logic signed [63:0] p;
        int                 sh;
        logic signed [31:0] a;
        dp_model = 32'h0;
        case (op)
            3'b001: dp_model = acc + in0 * in1;
            3'b010: begin
                p = $signed({{32{in0[31]}}, in0}) * $signed({{32{in1[31]}}, in1});
                p = (p + 64'sh4000_0000) >>> 31;
                dp_model = p[31:0];
            end
            3'b100: begin
                sh = -$signed(in1);
                a  = $signed(acc);
                if (sh <= 0 || sh > 31) dp_model = acc;
                else dp_model = 32'((a + (32'sd1 <<< (sh - 1))) >>> sh);
            end
            default: dp_model = 32'h0;
        endcase
    endfunction

    always_comb dp_result = dp_model(dp_op, dp_in0, dp_in1, dp_acc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Presents one command at a negedge; returns at the next negedge, after
    // the accept edge.
    task automatic send(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("cmd_ready_before_cmd", 32'(cmd_ready), 32'h1);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0    = a;
        cmd_payload_inputs_1    = b;
        @(negedge clk);
        cmd_valid               = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0    = '0;
        cmd_payload_inputs_1    = '0;
    endtask

    // Waits (bounded) for rsp_valid; returns edges counted after the accept.
    task automatic wait_rsp(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 64) begin
            @(negedge clk);
            edges++;
        end
    endtask

    typedef struct {
        string       name;
        logic [9:0]  fid;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int          edges;
        logic [2:0]  ops[8];
        logic [31:0] held;

        vecs[0]  = '{"config",      10'h009, 32'h4000_0000, 32'hFFFF_FFFE, 32'h0};
        vecs[1]  = '{"push_a1",     10'h000, 32'd2,         32'd3,         32'd1};
        vecs[2]  = '{"push_a2",     10'h000, 32'd4,         32'd5,         32'd2};
        vecs[3]  = '{"push_a3",     10'h000, 32'hFFFF_FFFF, 32'd6,         32'd3};
        vecs[4]  = '{"push_b1",     10'h000, 32'd1,         32'd1,         32'd1};
        vecs[5]  = '{"push_b2",     10'h000, 32'd2,         32'd2,         32'd2};
        vecs[6]  = '{"push_b3",     10'h000, 32'd3,         32'd3,         32'd3};
        vecs[7]  = '{"push_b4",     10'h000, 32'd4,         32'd4,         32'd4};
        vecs[8]  = '{"push_full",   10'h000, 32'd5,         32'd5,         32'hFFFF_FFFF};
        vecs[9]  = '{"clear",       10'h003, 32'd0,         32'd0,         32'd4};
        vecs[10] = '{"push_after",  10'h000, 32'd7,         32'd8,         32'd1};
        vecs[11] = '{"opcode5",     10'h015, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0};
        vecs[12] = '{"opcode7",     10'h01F, 32'h1234_5678, 32'h8765_4321, 32'h0};

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0 = '0;
        cmd_payload_inputs_1 = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_payload",   rsp_payload_outputs_0, 32'h0);
        check("rst_dp_op",     32'(dp_op), 32'h0);
        check("rst_dp_acc",    dp_acc, 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_cfg_bits",  32'({dp_simd_en, dp_layer_one_en}), 32'h0);

        // Config + three pushes
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].fid, vecs[i].in0, vecs[i].in1);
            check({vecs[i].name, "_valid"}, 32'(rsp_valid), 32'h1);
            check(vecs[i].name, rsp_payload_outputs_0, vecs[i].exp_rsp);
        end
        check("cfg_simd_layer1", 32'({dp_simd_en, dp_layer_one_en}), 32'h2);

        // RUN with 3 entries, bias 100: acc 120 -> RDH 60 -> RCDBPOT 15
        send(10'h002, 32'd100, 32'd0);
        edges = 0;
        while (!rsp_valid && edges < 8) begin
            ops[edges] = dp_op;
            if (edges < 3) begin
                check("mac_in0", dp_in0, vecs[edges + 1].in0);
                check("mac_in1", dp_in1, vecs[edges + 1].in1);
            end
            @(negedge clk);
            edges++;
        end
        check("run3_latency", 32'(edges), 32'd5);
        check("run3_dp_ops", {17'h0, ops[0], ops[1], ops[2], ops[3], ops[4]},
              {17'h0, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100});
        check("run3_result", rsp_payload_outputs_0, 32'd15);
        check("run3_idle_dp_op", 32'(dp_op), 32'h0);

        // Overflow, clear, post-clear push, unused opcodes
        for (int i = 4; i < 13; i++) begin
            send(vecs[i].fid, vecs[i].in0, vecs[i].in1);
            check({vecs[i].name, "_valid"}, 32'(rsp_valid), 32'h1);
            check(vecs[i].name, rsp_payload_outputs_0, vecs[i].exp_rsp);
        end
        check("op5_cfg_bits_kept", 32'({dp_simd_en, dp_layer_one_en}), 32'h2);

        // RUN with the single pair (7,8), bias 4: 60 -> 30 -> 8
        send(10'h002, 32'd4, 32'd0);
        wait_rsp(edges);
        check("run1_latency", 32'(edges), 32'd3);
        check("run1_result", rsp_payload_outputs_0, 32'd8);

        // Empty RUN with back-pressure: 0x7FFFFFFF -> 0x40000000 -> 0x10000000
        @(negedge clk);
        rsp_ready = 1'b0;
        send(10'h002, 32'h7FFF_FFFF, 32'd0);
        check("run0_first_op", 32'(dp_op), 32'(3'b010));
        wait_rsp(edges);
        check("run0_latency", 32'(edges), 32'd2);
        held = rsp_payload_outputs_0;
        check("run0_result", held, 32'h1000_0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hold_payload", rsp_payload_outputs_0, 32'h1000_0000);
            check("hold_valid_ready", 32'({rsp_valid, cmd_ready}), 32'h2);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_cmd_ready", 32'({rsp_valid, cmd_ready}), 32'h1);

        // Reset during the second MAC cycle of a 4-entry RUN
        for (int i = 0; i < 4; i++) begin
            send(10'h000, 32'(i + 1), 32'd9);
            check("fill4", rsp_payload_outputs_0, 32'(i + 1));
        end
        send(10'h002, 32'd0, 32'd0);
        @(negedge clk);
        check("second_mac_op", 32'(dp_op), 32'(3'b001));
        reset = 1'b1;
        #1;
        check("abort_dp_op", 32'(dp_op), 32'h0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        send(10'h000, 32'd3, 32'd3);
        check("push_after_abort", rsp_payload_outputs_0, 32'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/kws_mac_sequencer.md
Name: kws_mac_sequencer

Overview:
- Command-level controller placed between the CPU CFU port and the KWS arithmetic datapath: the MAC unit, the rounding doubling high unit (RDH) and the rounding clamping divide-by-power-of-two unit (RCDBPOT).
- Buffers input/filter word pairs in an internal FIFO and holds requantization config.
- On a RUN command, sequences one full output-channel computation through the shared datapath: bias load, N MACs, RDH, RCDBPOT. Returns the result over the same CFU handshake.
- The datapath is external and purely combinational. This block drives its operands and select, and registers the result.

Parameters:
DEPTH, 8, pair-FIFO entries; power of two, 2..64
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cmd_valid  in  1  CPU command valid
cmd_ready  out  1  command accept
cmd_payload_function_id  in  10  [2:0] opcode, [3] simd_en, [4] layer_one_en (sampled by CONFIG only)
cmd_payload_inputs_0  in  32  operand rs1
cmd_payload_inputs_1  in  32  operand rs2
rsp_valid  out  1  response valid
rsp_ready  in  1  CPU response accept
rsp_payload_outputs_0  out  32  response data
dp_op  out  3  one-hot datapath select: 001 MAC, 010 RDH, 100 RCDBPOT, 000 idle
dp_simd_en  out  1  registered config bit to MAC
dp_layer_one_en  out  1  registered config bit to MAC
dp_in0  out  32  datapath operand 0
dp_in1  out  32  datapath operand 1
dp_acc  out  32  current accumulator (MAC curr_acc / RCDBPOT dividend)
dp_result  in  32  combinational datapath result for the current dp_op

Behaviour:
- Reset values:
  - Registers and outputs: FIFO empty, count 0, acc 0, mult 0, shift 0, simd/layer_one 0.
  - Handshake and datapath: rsp_valid 0, rsp_payload 0, state IDLE, dp_op 000.
  - Reset mid-RUN aborts the run, and the FIFO contents are discarded.
- States: IDLE, MAC, RDH, SHIFT, RESP.
- cmd_ready = (state==IDLE) && !rsp_valid. A command is accepted on a clock edge where cmd_valid && cmd_ready.
- Opcodes:
  - 0 PUSH: push {inputs_0, inputs_1}.
    - Not full: response = new count (zero-extended).
    - Full: pair dropped, response 32'hFFFF_FFFF.
    - Response 1 cycle after accept.
  - 1 CONFIG: mult<=inputs_0, shift<=inputs_1, simd<=fid[3], layer_one<=fid[4]. Response 0, 1 cycle.
  - 2 RUN: acc<=inputs_0 (bias). Next state is MAC if count>0, else RDH.
  - 3 CLEAR: FIFO emptied. Response = entries discarded. 1 cycle.
  - 4-7: response 0, 1 cycle, no state change.
- MAC state, one cycle per entry:
  - dp_op=001, dp_in0=head.input, dp_in1=head.filter, dp_acc=acc.
  - Edge: acc<=dp_result, pop head.
  - Leaves to RDH after the last entry.
- RDH state, 1 cycle: dp_op=010, dp_in0=acc, dp_in1=mult. Edge: acc<=dp_result.
- SHIFT state, 1 cycle: dp_op=100, dp_in0=0, dp_in1=shift, dp_acc=acc. Edge: rsp_payload<=dp_result, rsp_valid<=1, go to RESP.
- RUN latency: rsp_valid rises N+2 edges after the accept edge, where N = count at accept.
- RESP/hold: rsp_valid and payload stay stable until rsp_ready is high on an edge, then rsp_valid<=0 and state returns to IDLE. Non-RUN responses follow the same rule.
- Outside MAC/RDH/SHIFT: dp_op=000 and dp_in0=dp_in1=0. dp_acc always equals acc.
- FIFO: circular, pointers wrap modulo DEPTH. After RUN the FIFO is empty. PUSH is impossible during RUN because cmd_ready is 0.
- Arithmetic: this block does no arithmetic on data. It only stores and forwards values.

Test Plan:
- CONFIG mult=0x4000_0000 shift=0xFFFF_FFFE. PUSH 3 pairs (each response 1,2,3). RUN bias=100 against a reference datapath model.
  -> dp_op sequence 001,001,001,010,100. rsp_valid exactly 5 edges after accept. Payload matches model. FIFO count 0.
- DEPTH=4: PUSH 5 pairs -> responses 1,2,3,4,0xFFFF_FFFF. CLEAR -> response 4. Subsequent PUSH -> 1.
- RUN with empty FIFO, bias=0x7FFF_FFFF -> no MAC cycle. RDH then RCDBPOT. rsp_valid 2 edges after accept.
- Hold rsp_ready low 6 cycles after a RUN response -> payload stable, cmd_ready 0 throughout. Release -> cmd_ready high the following cycle.
- Assert reset during the second MAC cycle of a 4-entry RUN -> dp_op 000, rsp_valid 0, count 0 immediately. A new PUSH returns 1.
- Opcode 5 with arbitrary operands -> response 0 after 1 cycle. Config and FIFO unchanged, checked by a following RUN.
